// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl_pkg : shared opcodes, funct3 codes, FSM states, lane helpers
// Rev 1.0
// ============================================================================
package mem_access_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return is_load;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic addr_aligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// mem_lane_align : picks the load lane from a memory word and extends it
// Rev 1.0
// ============================================================================
import mem_access_ctrl_pkg::*;

module mem_lane_align (
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo)
      2'd0:    w_byte = rd_word[7:0];
      2'd1:    w_byte = rd_word[15:8];
      2'd2:    w_byte = rd_word[23:16];
      default: w_byte = rd_word[31:24];
    endcase
    w_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    // funct3[2] set selects zero extension.
    case (funct3[1:0])
      2'b00:   data = {{24{w_byte[7]  & ~funct3[2]}}, w_byte};
      2'b01:   data = {{16{w_half[15] & ~funct3[2]}}, w_half};
      default: data = rd_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : sequences LOAD/STORE accesses over a req/ack memory port
// Rev 1.0
// ============================================================================
import mem_access_ctrl_pkg::*;

module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              load_we,
  output logic              misalign,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic              r_lat_load;
  logic [2:0]        r_lat_f3;
  logic [1:0]        r_lat_lo;
  logic              r_done;
  logic              r_load_we;
  logic              r_misalign;
  logic              r_timeout;
  logic [31:0]       r_rdata;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_mem_op;
  logic              w_fault;
  logic              w_accept;
  logic              w_cnt_last;
  logic              w_stall;
  logic [31:0]       w_rdata_ext;

  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);
  assign w_mem_op   = issue & (w_is_load | w_is_store);
  assign w_fault    = ~f3_legal(w_is_load, funct3) | ~addr_aligned(funct3[1:0], addr[1:0]);
  assign w_accept   = (r_state == ST_IDLE) & w_mem_op & ~w_fault;
  assign w_cnt_last = (r_cnt == c_cnt_last);

  mem_lane_align u_lane_align (
    .rd_word (mem_rdata),
    .addr_lo (r_lat_lo),
    .funct3  (r_lat_f3),
    .data    (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_WAIT_ACK;
          w_stall     = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        w_stall = 1'b1;
        if (mem_ack || w_cnt_last) w_state_nxt = ST_RESP;
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= 8'd0;
      r_lat_load <= 1'b0;
      r_lat_f3   <= 3'd0;
      r_lat_lo   <= 2'd0;
      r_done     <= 1'b0;
      r_load_we  <= 1'b0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      r_rdata    <= 32'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_done     <= 1'b0;
      r_load_we  <= 1'b0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req      <= 1'b1;
            r_we       <= w_is_store;
            r_addr     <= {addr[ADDR_W-1:2], 2'b00};
            r_be       <= lane_be(funct3[1:0], addr[1:0]);
            r_wdata    <= lane_wdata(funct3[1:0], wdata);
            r_lat_load <= w_is_load;
            r_lat_f3   <= funct3;
            r_lat_lo   <= addr[1:0];
            r_cnt      <= 8'd0;
          end else if (w_mem_op) begin
            r_misalign <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          // An ack arriving on the last count still completes normally.
          if (mem_ack) begin
            r_req     <= 1'b0;
            r_done    <= 1'b1;
            r_load_we <= r_lat_load;
            r_rdata   <= r_lat_load ? w_rdata_ext : 32'd0;
          end else if (w_cnt_last) begin
            r_req     <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_rdata   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall       = w_stall;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign load_we     = r_load_we;
  assign misalign    = r_misalign;
  assign timeout_err = r_timeout;
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_be      = r_be;
  assign mem_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_access_ctrl : vector table, reset sequences and random accesses
// Rev 1.0
// ============================================================================
module tb_mem_access_ctrl;

  localparam int TMO = 16;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    int          k;      // ack cycle, 0 = never
  } stim_t;

  typedef struct {
    bit          misalign;
    int          done_cyc; // -1 = no completion
    logic [31:0] rdata;
    bit          load_we;
    bit          tout;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] maddr;
    bit          we;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        stall, done, load_we, misalign, timeout_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .opcode(opcode), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .load_we(load_we), .misalign(misalign), .timeout_err(timeout_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model built directly from the access rules.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    int size, lo;
    bit is_ld, is_st, legal;
    logic [31:0] v, mask;
    e = '{misalign: 0, done_cyc: -1, rdata: 0, load_we: 0, tout: 0,
          be: 0, wd: 0, maddr: 0, we: 0};
    is_ld = (s.op == 7'h03);
    is_st = (s.op == 7'h23);
    if (!is_ld && !is_st) return e;
    legal = is_ld ? (s.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (s.f3 <= 3'd2);
    size  = 1 << int'(s.f3[1:0]);
    lo    = int'(s.addr[1:0]);
    if (!legal || (lo % size) != 0) begin
      e.misalign = 1;
      return e;
    end
    e.we    = is_st;
    e.maddr = s.addr & 32'hFFFF_FFFC;
    e.be    = 4'(((1 << size) - 1) << lo);
    if (size == 1)      e.wd = (s.wdata & 32'hFF) * 32'h0101_0101;
    else if (size == 2) e.wd = (s.wdata & 32'hFFFF) * 32'h0001_0001;
    else                e.wd = s.wdata;
    if (s.k >= 1 && s.k <= TMO) begin
      e.done_cyc = s.k + 1;
      if (is_ld) begin
        v = s.rdat >> (8 * lo);
        if (size < 4) begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          v = v & mask;
          if (s.f3 < 3'd4 && v[8*size-1]) v = v | ~mask;
        end
        e.rdata   = v;
        e.load_we = 1;
      end
    end else begin
      e.done_cyc = TMO + 1;
      e.tout     = 1;
    end
    return e;
  endfunction

  // Issue one instruction in an IDLE cycle (cycle 0) and observe until done.
  task automatic run_access(input stim_t s, output exp_t o, output int stall_cyc,
                            output int req_cyc, output bit stable);
    bit got_req, fin;
    o = '{misalign: 0, done_cyc: -1, rdata: 0, load_we: 0, tout: 0,
          be: 0, wd: 0, maddr: 0, we: 0};
    stall_cyc = 0; req_cyc = 0; stable = 1; got_req = 0; fin = 0;
    issue = 1'b1; opcode = s.op; funct3 = s.f3; addr = s.addr;
    wdata = s.wdata; mem_rdata = s.rdat; mem_ack = 1'b0;
    #1;
    if (stall) stall_cyc++;
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(posedge clk); #1;
      if (misalign) o.misalign = 1;
      if (stall) stall_cyc++;
      if (mem_req) begin
        req_cyc++;
        if (!got_req) begin
          got_req = 1;
          o.be = mem_be; o.wd = mem_wdata; o.maddr = mem_addr; o.we = mem_we;
        end else if (mem_be !== o.be || mem_wdata !== o.wd ||
                     mem_addr !== o.maddr || mem_we !== o.we) begin
          stable = 0;
        end
      end
      if (done) begin
        o.done_cyc = c; o.rdata = rdata; o.load_we = load_we; o.tout = timeout_err;
        issue = 1'b0; mem_ack = 1'b0; fin = 1;
      end else begin
        if (c == 1 && !stall) issue = 1'b0;
        if (c >= 4 && !stall && !mem_req) fin = 1;
        mem_ack = (c == s.k);
      end
    end
    issue = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic compare(input string tag, input exp_t o, input exp_t e,
                         input int stall_cyc, input int req_cyc, input bit stable);
    int exp_stall, exp_req;
    exp_stall = (e.done_cyc > 0) ? e.done_cyc : 0;
    exp_req   = (e.done_cyc > 0) ? e.done_cyc - 1 : 0;
    chk({tag, ".misalign"}, 32'(o.misalign), 32'(e.misalign));
    chk({tag, ".done_cyc"}, 32'(o.done_cyc), 32'(e.done_cyc));
    chk({tag, ".rdata"},    o.rdata, e.rdata);
    chk({tag, ".load_we"},  32'(o.load_we), 32'(e.load_we));
    chk({tag, ".timeout"},  32'(o.tout), 32'(e.tout));
    chk({tag, ".mem_be"},   32'(o.be), 32'(e.be));
    chk({tag, ".mem_wdata"}, o.wd, e.wd);
    chk({tag, ".mem_addr"}, o.maddr, e.maddr);
    chk({tag, ".mem_we"},   32'(o.we), 32'(e.we));
    chk({tag, ".stall_cyc"}, 32'(stall_cyc), 32'(exp_stall));
    chk({tag, ".req_cyc"},  32'(req_cyc), 32'(exp_req));
    chk({tag, ".req_stable"}, 32'(stable), 32'd1);
  endtask

  vec_t  vecs[16];
  exp_t  obs;
  int    sc, rc;
  bit    st;
  stim_t rs;
  int    quiet;

  initial begin
    vecs[0]  = '{'{7'h03, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 3},
                 '{0, 4,  32'hDEADBEEF, 1, 0, 4'hF, 32'h0,        32'h100, 0}};
    vecs[1]  = '{'{7'h03, 3'd0, 32'h103, 32'h55,       32'h80FF0000, 2},
                 '{0, 3,  32'hFFFFFF80, 1, 0, 4'h8, 32'h55555555, 32'h100, 0}};
    vecs[2]  = '{'{7'h03, 3'd4, 32'h103, 32'h55,       32'h80FF0000, 2},
                 '{0, 3,  32'h00000080, 1, 0, 4'h8, 32'h55555555, 32'h100, 0}};
    vecs[3]  = '{'{7'h23, 3'd1, 32'h202, 32'h1234ABCD, 32'h0,        1},
                 '{0, 2,  32'h0,        0, 0, 4'hC, 32'hABCDABCD, 32'h200, 1}};
    vecs[4]  = '{'{7'h03, 3'd2, 32'h101, 32'h0,        32'h0,        1},
                 '{1, -1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   0}};
    vecs[5]  = '{'{7'h23, 3'd3, 32'h100, 32'h0,        32'h0,        1},
                 '{1, -1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   0}};
    vecs[6]  = '{'{7'h03, 3'd2, 32'h40,  32'h0,        32'h12345678, 0},
                 '{0, 17, 32'h0,        0, 1, 4'hF, 32'h0,        32'h40,  0}};
    vecs[7]  = '{'{7'h33, 3'd2, 32'h0,   32'h0,        32'h0,        1},
                 '{0, -1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   0}};
    vecs[8]  = '{'{7'h03, 3'd1, 32'h302, 32'h0,        32'h80017FFF, 2},
                 '{0, 3,  32'hFFFF8001, 1, 0, 4'hC, 32'h0,        32'h300, 0}};
    vecs[9]  = '{'{7'h03, 3'd5, 32'h302, 32'h0,        32'h80017FFF, 2},
                 '{0, 3,  32'h00008001, 1, 0, 4'hC, 32'h0,        32'h300, 0}};
    vecs[10] = '{'{7'h23, 3'd0, 32'h11,  32'hA5,       32'h0,        4},
                 '{0, 5,  32'h0,        0, 0, 4'h2, 32'hA5A5A5A5, 32'h10,  1}};
    vecs[11] = '{'{7'h23, 3'd2, 32'h20,  32'hCAFEF00D, 32'h0,        1},
                 '{0, 2,  32'h0,        0, 0, 4'hF, 32'hCAFEF00D, 32'h20,  1}};
    vecs[12] = '{'{7'h03, 3'd0, 32'h101, 32'h0,        32'h00007F00, 2},
                 '{0, 3,  32'h0000007F, 1, 0, 4'h2, 32'h0,        32'h100, 0}};
    vecs[13] = '{'{7'h03, 3'd2, 32'h80,  32'h0,        32'h0BADC0DE, 16},
                 '{0, 17, 32'h0BADC0DE, 1, 0, 4'hF, 32'h0,        32'h80,  0}};
    vecs[14] = '{'{7'h03, 3'd1, 32'h103, 32'h0,        32'h0,        1},
                 '{1, -1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   0}};
    vecs[15] = '{'{7'h23, 3'd4, 32'h100, 32'h0,        32'h0,        1},
                 '{1, -1, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,   0}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({stall, done, load_we, misalign, timeout_err, mem_req, mem_we}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_access(vecs[i].s, obs, sc, rc, st);
      compare($sformatf("vec%0d", i), obs, vecs[i].e, sc, rc, st);
    end

    // Reset in the second WAIT_ACK cycle, then a stray ack in IDLE.
    issue = 1'b1; opcode = 7'h03; funct3 = 3'd2; addr = 32'h100; mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("midrst_req_c1", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    chk("midrst_req_c2", 32'(mem_req), 32'd1);
    rst_n = 1'b0; issue = 1'b0;
    @(posedge clk); #1;
    chk("midrst_req_after", 32'(mem_req), 32'd0);
    chk("midrst_stall_after", 32'(stall), 32'd0);
    chk("midrst_done_after", 32'(done | load_we), 32'd0);
    rst_n = 1'b1; mem_ack = 1'b1;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (done || load_we || mem_req || stall) quiet++;
    end
    chk("late_ack_ignored", 32'(quiet), 32'd0);
    rs = '{7'h03, 3'd2, 32'h104, 32'h0, 32'h13579BDF, 2};
    run_access(rs, obs, sc, rc, st);
    compare("after_rst", obs, model(rs), sc, rc, st);

    // Randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      rs.op = (r < 4) ? 7'h03 : (r < 8) ? 7'h23 : 7'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 4);
        rs.f3 = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
      end else begin
        rs.f3 = 3'($urandom_range(0, 7));
      end
      rs.addr  = $urandom & 32'h0000_FFFF;
      rs.wdata = $urandom;
      rs.rdat  = $urandom;
      r = $urandom_range(0, 9);
      rs.k = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 15 : $urandom_range(1, 6);
      run_access(rs, obs, sc, rc, st);
      compare($sformatf("rnd%0d", n), obs, model(rs), sc, rc, st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
